// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - command-level I2C master with open-drain SCL/SDA and clock-stretch support
module i2c_master_ctrl #(
    parameter int CLK_DIV    = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_nak,
    output logic                  rsp_err,
    output logic                  bus_held,
    input  logic                  scl_i,
    output logic                  scl_o,
    input  logic                  sda_i,
    output logic                  sda_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_ACK   = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LASTD = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] CMD_START    = 3'd0;
    localparam logic [2:0] CMD_STOP     = 3'd1;
    localparam logic [2:0] CMD_WRITE    = 3'd2;
    localparam logic [2:0] CMD_READ_ACK = 3'd3;
    localparam logic [2:0] CMD_READ_NAK = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_XFER, S_DONE} state_t;

    state_t                state;
    logic [1:0]            q;
    logic [CW-1:0]         cnt;
    logic [1:0]            settle;
    logic [BW-1:0]         bitn;
    logic                  is_read;
    logic                  ack_val;
    logic                  ack_s;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rxreg;
    logic                  scl_m, scl_s, sda_m, sda_s;
    logic                  adv;
    logic                  q_end;

    // Q1 ignores its first two cycles so the synchronizer reflects the released SCL
    // before high time is counted; this keeps Q1 at CLK_DIV+2 whatever SCL was before.
    assign adv   = (q != 2'd1) || (settle == 2'd0 && scl_s);
    assign q_end = adv && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            q         <= 2'd0;
            cnt       <= '0;
            settle    <= 2'd0;
            bitn      <= '0;
            is_read   <= 1'b0;
            ack_val   <= 1'b0;
            ack_s     <= 1'b0;
            shreg     <= '0;
            rxreg     <= '0;
            scl_m     <= 1'b1;
            scl_s     <= 1'b1;
            sda_m     <= 1'b1;
            sda_s     <= 1'b1;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nak   <= 1'b0;
            rsp_err   <= 1'b0;
            bus_held  <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
        end else begin
            scl_m     <= scl_i;
            scl_s     <= scl_m;
            sda_m     <= sda_i;
            sda_s     <= sda_m;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cnt       <= '0;
                        q         <= 2'd0;
                        settle    <= 2'd0;
                        bitn      <= '0;
                        is_read   <= (cmd != CMD_WRITE);
                        ack_val   <= (cmd == CMD_READ_NAK);
                        shreg     <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        state     <= S_DONE;
                        case (cmd)
                            CMD_START: begin
                                state <= S_START;
                                sda_o <= 1'b1;
                            end
                            CMD_STOP: if (bus_held) begin
                                state <= S_STOP;
                                sda_o <= 1'b0;
                            end
                            CMD_WRITE: if (bus_held) begin
                                state <= S_XFER;
                                sda_o <= cmd_wdata[DATA_WIDTH-1];
                            end
                            CMD_READ_ACK, CMD_READ_NAK: if (bus_held) begin
                                state <= S_XFER;
                                sda_o <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    // rejected command: no bus activity, only the error response
                    state     <= S_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    if (adv) cnt <= q_end ? '0 : cnt + 1'b1;
                    if (q == 2'd1 && settle != 2'd0) settle <= settle - 2'd1;
                    if (q_end) begin
                        q <= q + 2'd1;
                        case (q)
                            2'd0: begin
                                scl_o  <= 1'b1;
                                settle <= 2'd2;
                            end
                            2'd1: begin
                                if (state == S_START) sda_o <= 1'b0;
                                if (state == S_STOP)  sda_o <= 1'b1;
                            end
                            2'd2: begin
                                if (state != S_STOP) scl_o <= 1'b0;
                                if (state == S_XFER) begin
                                    if (bitn == BIT_ACK) ack_s <= sda_s;
                                    else rxreg <= {rxreg[DATA_WIDTH-2:0], sda_s};
                                end
                            end
                            default: begin
                                if (state == S_XFER && bitn != BIT_ACK) begin
                                    bitn <= bitn + 1'b1;
                                    if (bitn == BIT_LASTD) sda_o <= is_read ? ack_val : 1'b1;
                                    else sda_o <= is_read ? 1'b1 : shreg[DATA_WIDTH-2];
                                    shreg <= shreg << 1;
                                end else begin
                                    state     <= S_IDLE;
                                    rsp_valid <= 1'b1;
                                    cmd_ready <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    sda_o     <= 1'b1;
                                    if (state == S_START) bus_held <= 1'b1;
                                    if (state == S_STOP)  bus_held <= 1'b0;
                                    if (state == S_XFER) begin
                                        if (is_read) begin
                                            rsp_rdata <= rxreg;
                                            rsp_nak   <= 1'b0;
                                        end else begin
                                            rsp_nak <= ack_s;
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
